// File: rtl/opll_bus_pkg.sv
// Shared types and constants for the YM2413 (OPLL) host write path.
// Holds the writer FSM states, the request bundle and default recovery waits.
package opll_bus_pkg;

  localparam int OPLL_ADDR_WAIT = 12;
  localparam int OPLL_DATA_WAIT = 84;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STROBE,
    ST_A_WAIT,
    ST_D_SETUP,
    ST_D_STROBE,
    ST_D_WAIT
  } state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

endpackage

// File: rtl/opll_wr_fifo.sv
// Small synchronous request FIFO with occupancy count.
// Push is ignored when full and pop is ignored when empty.
module opll_wr_fifo
  import opll_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  req_t        i_wdata,
  input  logic        i_pop,
  output req_t        o_rdata,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count
);

  req_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/opll_bus_writer.sv
// OPLL CPU-bus write initiator: buffers (reg, value) requests and
// replays each as an address cycle then a data cycle with OPLL waits.
module opll_bus_writer
  import opll_bus_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int STROBE_CYCLES  = 2,
  parameter int ADDR_WAIT      = OPLL_ADDR_WAIT,
  parameter int DATA_WAIT      = OPLL_DATA_WAIT,
  parameter bit SKIP_SAME_ADDR = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic [7:0] bus_d,
  output logic       bus_a0,
  output logic       bus_cs_n,
  output logic       bus_we_n,
  output logic       busy
);

  localparam int M1  = (DATA_WAIT > STROBE_CYCLES) ? DATA_WAIT : STROBE_CYCLES;
  localparam int CMX = (ADDR_WAIT > M1) ? ADDR_WAIT : M1;
  localparam int CW  = $clog2(CMX + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  req_t           r_req;
  req_t           w_req_nxt;
  req_t           w_head;
  req_t           w_wdata;
  logic [7:0]     r_bus_d;
  logic [7:0]     w_bus_d_nxt;
  logic           r_bus_a0;
  logic           w_bus_a0_nxt;
  logic           r_cs_n;
  logic           r_we_n;
  logic           w_strobe_nxt;
  logic [7:0]     r_last_addr;
  logic           r_last_vld;
  logic           w_last_upd;
  logic           w_pop;
  logic           w_push;
  logic           w_full;
  logic           w_empty;
  logic           w_hit;
  logic           w_done;
  logic           w_start;
  logic [FCW-1:0] w_count;

  assign w_wdata   = '{addr: req_addr, data: req_data};
  assign w_push    = req_valid & ~w_full;
  assign req_ready = ~w_full;
  assign w_done    = (r_cnt == CW'(1));
  assign w_hit     = SKIP_SAME_ADDR && r_last_vld &&
                     (w_head.addr == r_last_addr);

  opll_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
    w_req_nxt    = r_req;
    w_bus_d_nxt  = r_bus_d;
    w_bus_a0_nxt = r_bus_a0;
    w_pop        = 1'b0;
    w_last_upd   = 1'b0;
    w_start      = 1'b0;
    unique case (r_state)
      ST_IDLE: w_start = 1'b1;
      ST_A_SETUP: if (w_done) begin
        w_state_nxt = ST_A_STROBE;
        w_cnt_nxt   = CW'(STROBE_CYCLES);
      end
      ST_A_STROBE: if (w_done) begin
        w_state_nxt = ST_A_WAIT;
        w_cnt_nxt   = CW'(ADDR_WAIT);
        w_last_upd  = 1'b1;
      end
      ST_A_WAIT: if (w_done) begin
        w_state_nxt  = ST_D_SETUP;
        w_cnt_nxt    = CW'(1);
        w_bus_d_nxt  = r_req.data;
        w_bus_a0_nxt = 1'b1;
      end
      ST_D_SETUP: if (w_done) begin
        w_state_nxt = ST_D_STROBE;
        w_cnt_nxt   = CW'(STROBE_CYCLES);
      end
      ST_D_STROBE: if (w_done) begin
        w_state_nxt = ST_D_WAIT;
        w_cnt_nxt   = CW'(DATA_WAIT);
      end
      ST_D_WAIT: w_start = w_done;
      default: w_state_nxt = ST_IDLE;
    endcase
    // Shared dispatch from IDLE and from the end of data recovery.
    if (w_start) begin
      if (!w_empty) begin
        w_pop     = 1'b1;
        w_req_nxt = w_head;
        w_cnt_nxt = CW'(1);
        if (w_hit) begin
          w_state_nxt  = ST_D_SETUP;
          w_bus_d_nxt  = w_head.data;
          w_bus_a0_nxt = 1'b1;
        end else begin
          w_state_nxt  = ST_A_SETUP;
          w_bus_d_nxt  = w_head.addr;
          w_bus_a0_nxt = 1'b0;
        end
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  assign w_strobe_nxt = (w_state_nxt == ST_A_STROBE) ||
                        (w_state_nxt == ST_D_STROBE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req       <= '0;
      r_bus_d     <= '0;
      r_bus_a0    <= 1'b0;
      r_cs_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_last_addr <= '0;
      r_last_vld  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_req    <= w_req_nxt;
      r_bus_d  <= w_bus_d_nxt;
      r_bus_a0 <= w_bus_a0_nxt;
      r_cs_n   <= ~w_strobe_nxt;
      r_we_n   <= ~w_strobe_nxt;
      if (w_last_upd) begin
        r_last_addr <= r_req.addr;
        r_last_vld  <= 1'b1;
      end
    end
  end

  assign bus_d    = r_bus_d;
  assign bus_a0   = r_bus_a0;
  assign bus_cs_n = r_cs_n;
  assign bus_we_n = r_we_n;
  assign busy     = (w_count != '0) || (r_state != ST_IDLE);

endmodule
